// File: rtl/ball_field_pkg.sv
// Shared types and helpers for the N-ball physics/render engine.
// Positions and velocities are signed fixed point with FRAC_BITS fractional bits.
package ball_field_pkg;

    localparam int FRAC_BITS = 6;
    localparam int COORD_W   = 16;

    typedef logic [15:0]               rgb565_t;
    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic [5:0]                radius_t;

    typedef struct packed {
        coord_t  x;
        coord_t  y;
        coord_t  vx;
        coord_t  vy;
        radius_t radius;
        rgb565_t color;
        logic    en;
    } ball_state_t;

    typedef enum logic {
        IDLE,
        SWEEP
    } fsm_state_t;

    function automatic coord_t pix_to_fix(input logic [8:0] px);
        return coord_t'({{(COORD_W-9){1'b0}}, px}) <<< FRAC_BITS;
    endfunction

    function automatic logic [31:0] sq32(input coord_t v);
        logic signed [31:0] w;
        w = 32'(v);
        return w * w;
    endfunction

endpackage

// File: rtl/ball_field_if.sv
// Config, pixel query/result and status bundle between the engine and its host.
interface ball_field_if
    import ball_field_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int IDX_W     = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
);
    logic                 tick;
    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic [8:0]           cfg_x;
    logic [7:0]           cfg_y;
    coord_t               cfg_vx;
    radius_t              cfg_radius;
    rgb565_t              cfg_color;
    logic                 cfg_en;
    logic                 px_valid;
    logic [8:0]           px_x;
    logic [7:0]           px_y;
    logic                 frame_sync;
    logic                 out_valid;
    logic [NUM_BALLS-1:0] out_hit;
    rgb565_t              out_color;
    logic                 busy;
    logic                 overrun;

    modport master (
        output tick, cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_radius, cfg_color, cfg_en,
        output px_valid, px_x, px_y, frame_sync,
        input  out_valid, out_hit, out_color, busy, overrun
    );

    modport slave (
        input  tick, cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_radius, cfg_color, cfg_en,
        input  px_valid, px_x, px_y, frame_sync,
        output out_valid, out_hit, out_color, busy, overrun
    );

endinterface

// File: rtl/ball_physics_step.sv
// Combinational one-tick update of a single ball: move, bounce off the walls, apply gravity.
// Zero latency; disabled slots pass through unchanged.
module ball_physics_step
    import ball_field_pkg::*;
#(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int TOP_Y    = 32,
    parameter int GRAVITY  = 1
) (
    input  ball_state_t cur_i,
    output ball_state_t nxt_o
);

    localparam coord_t MAXX_BASE = coord_t'((SCREEN_W - 1) << FRAC_BITS);
    localparam coord_t MINY_BASE = coord_t'(TOP_Y << FRAC_BITS);
    localparam coord_t MAXY_BASE = coord_t'((SCREEN_H - 1) << FRAC_BITS);
    localparam coord_t GRAV      = coord_t'(GRAVITY);

    coord_t r_fix;
    coord_t nx;
    coord_t ny;

    always_comb begin
        r_fix = coord_t'({{(COORD_W-6){1'b0}}, cur_i.radius}) <<< FRAC_BITS;
        nx    = cur_i.x + cur_i.vx;
        ny    = cur_i.y - cur_i.vy;
        nxt_o = cur_i;
        if (cur_i.en) begin
            if (nx < r_fix || nx > MAXX_BASE - r_fix) begin
                nxt_o.vx = -cur_i.vx;
            end else begin
                nxt_o.x = nx;
            end
            // Screen y grows downward while vy is "up", hence y - vy.
            if (ny < MINY_BASE + r_fix || ny > MAXY_BASE - r_fix) begin
                nxt_o.vy = -cur_i.vy - GRAV;
            end else begin
                nxt_o.y  = ny;
                nxt_o.vy = cur_i.vy - GRAV;
            end
        end
    end

endmodule

// File: rtl/ball_field.sv
// N-ball engine: one-ball-per-cycle physics sweep per tick, 2-cycle render pipeline, no backpressure.
// Optional BALL_FIELD_SHADOW_EN renders from a frame_sync-latched shadow copy for tear-free frames.
module ball_field
    import ball_field_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter int TOP_Y     = 32,
    parameter int GRAVITY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    ball_field_if.slave bus
);

    localparam int               IDX_W    = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

    ball_state_t      slot_q [NUM_BALLS];
    ball_state_t      slot_d [NUM_BALLS];
    ball_state_t      cfg_slot;
    ball_state_t      phys_nxt;
    fsm_state_t       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             overrun_q;

    ball_physics_step #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .TOP_Y    (TOP_Y),
        .GRAVITY  (GRAVITY)
    ) u_step (
        .cur_i (slot_q[idx_q]),
        .nxt_o (phys_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tick) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (bus.tick) begin
                        overrun_q <= 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_slot.x      = pix_to_fix(bus.cfg_x);
        cfg_slot.y      = pix_to_fix({1'b0, bus.cfg_y});
        cfg_slot.vx     = bus.cfg_vx;
        cfg_slot.vy     = '0;
        cfg_slot.radius = bus.cfg_radius;
        cfg_slot.color  = bus.cfg_color;
        cfg_slot.en     = bus.cfg_en;
        slot_d = slot_q;
        if (state_q == SWEEP) begin
            slot_d[idx_q] = phys_nxt;
        end
        // Applied last so a host write to the slot being swept takes priority.
        if (bus.cfg_we) begin
            slot_d[bus.cfg_idx] = cfg_slot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_BALLS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    coord_t  rnd_x  [NUM_BALLS];
    coord_t  rnd_y  [NUM_BALLS];
    radius_t rnd_r  [NUM_BALLS];
    logic    rnd_en [NUM_BALLS];

`ifdef BALL_FIELD_SHADOW_EN
    coord_t  shd_x_q  [NUM_BALLS];
    coord_t  shd_y_q  [NUM_BALLS];
    radius_t shd_r_q  [NUM_BALLS];
    logic    shd_en_q [NUM_BALLS];
    logic    sync_pend_q;
    logic    copy_now;

    // A frame_sync seen mid-sweep is held until the sweep has finished.
    assign copy_now = !busy_q && (bus.frame_sync || sync_pend_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_pend_q <= 1'b0;
            for (int k = 0; k < NUM_BALLS; k++) begin
                shd_x_q[k]  <= '0;
                shd_y_q[k]  <= '0;
                shd_r_q[k]  <= '0;
                shd_en_q[k] <= 1'b0;
            end
        end else if (copy_now) begin
            sync_pend_q <= 1'b0;
            for (int k = 0; k < NUM_BALLS; k++) begin
                shd_x_q[k]  <= slot_q[k].x;
                shd_y_q[k]  <= slot_q[k].y;
                shd_r_q[k]  <= slot_q[k].radius;
                shd_en_q[k] <= slot_q[k].en;
            end
        end else if (bus.frame_sync) begin
            sync_pend_q <= 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_BALLS; k++) begin
            rnd_x[k]  = shd_x_q[k];
            rnd_y[k]  = shd_y_q[k];
            rnd_r[k]  = shd_r_q[k];
            rnd_en[k] = shd_en_q[k];
        end
    end
`else
    logic unused_frame_sync;
    assign unused_frame_sync = bus.frame_sync;

    always_comb begin
        for (int k = 0; k < NUM_BALLS; k++) begin
            rnd_x[k]  = slot_q[k].x;
            rnd_y[k]  = slot_q[k].y;
            rnd_r[k]  = slot_q[k].radius;
            rnd_en[k] = slot_q[k].en;
        end
    end
`endif

    coord_t               qx;
    coord_t               qy;
    logic                 vld_s1_q;
    coord_t               dx_q   [NUM_BALLS];
    coord_t               dy_q   [NUM_BALLS];
    radius_t              r_s1_q [NUM_BALLS];
    rgb565_t              col_s1_q [NUM_BALLS];
    logic [NUM_BALLS-1:0] en_s1_q;
    logic [NUM_BALLS-1:0] hit_d;
    rgb565_t              color_d;
    logic                 out_valid_q;
    logic [NUM_BALLS-1:0] out_hit_q;
    rgb565_t              out_color_q;

    assign qx = coord_t'({{(COORD_W-9){1'b0}}, bus.px_x});
    assign qy = coord_t'({{(COORD_W-8){1'b0}}, bus.px_y});

    always_comb begin
        hit_d   = '0;
        color_d = '0;
        for (int k = NUM_BALLS - 1; k >= 0; k--) begin
            hit_d[k] = en_s1_q[k] &&
                       (sq32(dx_q[k]) + sq32(dy_q[k]) <= 32'(r_s1_q[k]) * 32'(r_s1_q[k]));
            if (hit_d[k]) begin
                color_d = col_s1_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_s1_q    <= 1'b0;
            en_s1_q     <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= '0;
            out_color_q <= '0;
            for (int k = 0; k < NUM_BALLS; k++) begin
                dx_q[k]     <= '0;
                dy_q[k]     <= '0;
                r_s1_q[k]   <= '0;
                col_s1_q[k] <= '0;
            end
        end else begin
            vld_s1_q <= bus.px_valid;
            for (int k = 0; k < NUM_BALLS; k++) begin
                dx_q[k]     <= (rnd_x[k] >>> FRAC_BITS) - qx;
                dy_q[k]     <= (rnd_y[k] >>> FRAC_BITS) - qy;
                r_s1_q[k]   <= rnd_r[k];
                col_s1_q[k] <= slot_q[k].color;
                en_s1_q[k]  <= rnd_en[k];
            end
            out_valid_q <= vld_s1_q;
            out_hit_q   <= hit_d;
            out_color_q <= color_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_color = out_color_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_ball_field.sv
// Self-checking bench for ball_field: query vectors, a result scoreboard and multi-cycle corner cases.
module tb_ball_field;
    import ball_field_pkg::*;

    localparam int NB = 4;

    logic clk = 1'b0;
    logic reset;

    ball_field_if #(.NUM_BALLS(NB)) bus ();

    ball_field #(
        .NUM_BALLS (NB),
        .SCREEN_W  (320),
        .SCREEN_H  (240),
        .TOP_Y     (32),
        .GRAVITY   (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int qx; int qy; int hit; int col; } vec_t;
    typedef struct { logic [NB-1:0] hit; logic [15:0] col; } exp_t;

    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    vec_t    vecs[12];
    shortint m_x, m_y, m_vx, m_vy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input int x, input int y, input int vx,
                       input int r, input int col, input int en);
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = 2'(idx);
        bus.cfg_x      = 9'(x);
        bus.cfg_y      = 8'(y);
        bus.cfg_vx     = coord_t'(vx);
        bus.cfg_radius = 6'(r);
        bus.cfg_color  = 16'(col);
        bus.cfg_en     = 1'(en);
        step();
        bus.cfg_we     = 1'b0;
    endtask

    task automatic sync_frame();
        bus.frame_sync = 1'b1;
        step();
        bus.frame_sync = 1'b0;
    endtask

    task automatic query(input int x, input int y, input int hit, input int col);
        exp_t e;
        e.hit = NB'(hit);
        e.col = 16'(col);
        bus.px_valid = 1'b1;
        bus.px_x     = 9'(x);
        bus.px_y     = 8'(y);
        sb.push_back(e);
        step();
        bus.px_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
        chk("wait_idle", 32'(bus.busy), 32'd0);
        step();
    endtask

    task automatic do_tick(input string nm, input bit do_sync);
        int n;
        n = 0;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else break;
        end
        step();
        chk(nm, 32'(n), 32'd4);
        if (do_sync) sync_frame();
    endtask

    task automatic model_tick();
        shortint nx, ny;
        nx = m_x + m_vx;
        if (nx < 0 || nx > 319 * 64) m_vx = -m_vx;
        else m_x = nx;
        ny = m_y - m_vy;
        if (ny < 32 * 64 || ny > 239 * 64) m_vy = -m_vy - 1;
        else begin
            m_y  = ny;
            m_vy = m_vy - 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        reset = 1'b1;
        bus.tick = 0; bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_x = 0; bus.cfg_y = 0;
        bus.cfg_vx = 0; bus.cfg_radius = 0; bus.cfg_color = 0; bus.cfg_en = 0;
        bus.px_valid = 0; bus.px_x = 0; bus.px_y = 0; bus.frame_sync = 0;

        fork
            forever begin
                @(negedge clk);
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_hit", 32'(bus.out_hit), 32'(e.hit));
                        chk("out_color", 32'(bus.out_color), 32'(e.col));
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_hit", 32'(bus.out_hit), 32'd0);
        chk("rst_out_color", 32'(bus.out_color), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Single ball plus a disabled and a small enabled slot; back-to-back queries.
        cfg(0, 100, 100, 0, 10, 'hF800, 1);
        cfg(1, 20, 200, 0, 5, 'h1111, 0);
        cfg(3, 200, 150, 0, 5, 'h1234, 1);
        sync_frame();
        vecs = '{
            '{100, 100, 'b0001, 'hF800},
            '{111, 100, 0, 0},
            '{110, 100, 'b0001, 'hF800},
            '{100,  90, 'b0001, 'hF800},
            '{100,  89, 0, 0},
            '{107, 107, 'b0001, 'hF800},
            '{108, 107, 0, 0},
            '{ 20, 200, 0, 0},
            '{200, 150, 'b1000, 'h1234},
            '{205, 150, 'b1000, 'h1234},
            '{206, 150, 0, 0},
            '{197, 146, 'b1000, 'h1234}
        };
        for (int i = 0; i < 12; i++) query(vecs[i].qx, vecs[i].qy, vecs[i].hit, vecs[i].col);
        drain();

        // Overlapping slots: lowest index wins the colour.
        cfg(0, 50, 50, 0, 10, 'h001F, 1);
        cfg(2, 50, 50, 0, 12, 'h07E0, 1);
        sync_frame();
        query(50, 50, 'b0101, 'h001F);
        query(58, 50, 'b0101, 'h001F);
        query(61, 50, 'b0100, 'h07E0);
        query(63, 50, 0, 0);
        query(200, 150, 'b1000, 'h1234);
        drain();

        cfg(2, 0, 0, 0, 0, 0, 0);
        cfg(3, 0, 0, 0, 0, 0, 0);
        // Host write to slot 0 on the same edge the sweep updates slot 0.
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        cfg(0, 150, 120, 0, 3, 'hAAAA, 1);
        wait_idle();
        sync_frame();
        query(150, 120, 'b0001, 'hAAAA);
        query(50, 50, 0, 0);
        drain();

        // Horizontal motion and gravity start.
        cfg(0, 100, 100, 64, 10, 'hF800, 1);
        sync_frame();
        do_tick("busy_cycles_t1", 1'b1);
        query(101, 100, 'b0001, 'hF800);
        query(111, 100, 'b0001, 'hF800);
        query(90, 100, 0, 0);
        query(112, 100, 0, 0);
        drain();
        do_tick("busy_cycles_t2", 1'b1);
        query(112, 100, 'b0001, 'hF800);
        query(91, 100, 0, 0);
        drain();

        // Right-wall bounce: x held, vx negated, then moves back.
        cfg(0, 308, 100, 128, 10, 'hF800, 1);
        sync_frame();
        do_tick("busy_cycles_wall1", 1'b1);
        query(298, 100, 'b0001, 'hF800);
        query(297, 100, 0, 0);
        drain();
        do_tick("busy_cycles_wall2", 1'b1);
        query(296, 100, 'b0001, 'hF800);
        query(295, 100, 0, 0);
        query(316, 100, 'b0001, 'hF800);
        drain();

        // Zero-radius ball bouncing on both axes against a reference trajectory.
        cfg(0, 5, 230, -100, 0, 'hABCD, 1);
        sync_frame();
        m_x = 5 * 64; m_y = 230 * 64; m_vx = -100; m_vy = 0;
        for (int t = 0; t < 50; t++) begin
            do_tick("busy_cycles_traj", 1'b1);
            model_tick();
            query(int'(m_x >>> 6), int'(m_y >>> 6), 'b0001, 'hABCD);
            query(int'(m_x >>> 6) + 1, int'(m_y >>> 6), 0, 0);
        end
        drain();

        // Tick arriving mid-sweep is dropped and latches overrun.
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else break;
        end
        chk("overrun_sweep_tail", 32'(n), 32'd2);
        chk("overrun_set", 32'(bus.overrun), 32'd1);
        repeat (10) step();
        chk("overrun_no_resweep", 32'(bus.busy), 32'd0);
        chk("overrun_sticky", 32'(bus.overrun), 32'd1);

        // Asynchronous reset with a sweep and a query in flight.
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        bus.px_valid = 1'b1;
        bus.px_x = 9'd1;
        bus.px_y = 8'd1;
        step();
        bus.px_valid = 1'b0;
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_overrun", 32'(bus.overrun), 32'd0);
        step();
        #2;
        reset = 1'b0;
        repeat (4) step();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        // Render source after a tick, with and without frame_sync.
        cfg(0, 100, 100, 64, 0, 'hF800, 1);
        sync_frame();
        do_tick("busy_cycles_render", 1'b0);
`ifdef BALL_FIELD_SHADOW_EN
        query(100, 100, 'b0001, 'hF800);
        query(101, 100, 0, 0);
        drain();
        sync_frame();
`endif
        query(101, 100, 'b0001, 'hF800);
        query(100, 100, 0, 0);
        drain();

        // frame_sync during a sweep must still deliver the finished positions.
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        bus.frame_sync = 1'b1;
        step();
        bus.frame_sync = 1'b0;
        wait_idle();
        step();
        query(102, 100, 'b0001, 'hF800);
        query(101, 100, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
